// File: rtl/aes_pkg.sv
// Shared AES-128 types, tables and byte/word helpers for the iterative encryption core.
package aes_pkg;

  localparam int unsigned BLK_W      = 128;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned RND_W      = 4;
  localparam int unsigned NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constant lookup; unused indices yield zero.
  function automatic logic [7:0] rcon(input logic [RND_W-1:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Byte (r,c) lives at bit offset 127-8*(r+4c); row r rotates left by r columns.
  function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES-128 encryption round with on-the-fly next round key.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] state_i,
  input  logic [BLK_W-1:0] rk_i,
  input  logic [7:0]       rcon_i,
  input  logic             last_i,
  output logic [BLK_W-1:0] state_nxt_c,
  output logic [BLK_W-1:0] rk_nxt_c
);

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [BLK_W-1:0]  sb, sr, mc;

  always_comb begin
    w0 = rk_i[127:96] ^ sub_word(rot_word(rk_i[31:0])) ^ {rcon_i, 24'h000000};
    w1 = rk_i[95:64] ^ w0;
    w2 = rk_i[63:32] ^ w1;
    w3 = rk_i[31:0]  ^ w2;
    rk_nxt_c = {w0, w1, w2, w3};

    sb = {sub_word(state_i[127:96]), sub_word(state_i[95:64]),
          sub_word(state_i[63:32]),  sub_word(state_i[31:0])};
    sr = shift_rows(sb);
    // Final round omits MixColumns.
    mc = last_i ? sr : mix_columns(sr);
    state_nxt_c = mc ^ rk_nxt_c;
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor, one round per clock with valid/ready in and out.
// AES_KEY_PORT_EN adds a per-block key_in port; otherwise FIXED_KEY is used.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter logic [127:0] FIXED_KEY      = 128'h000102030405060708090a0b0c0d0e0f,
  parameter int unsigned  BYTE_ORDER_MSB = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
`ifdef AES_KEY_PORT_EN
  input  logic [BLK_W-1:0] key_in,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy
);

  if (BYTE_ORDER_MSB != 1) begin : g_byte_order_chk
    $error("aes_encrypt_iter supports only BYTE_ORDER_MSB == 1");
  end

  state_t           state_q, state_d;
  logic [BLK_W-1:0] data_q, data_d;
  logic [BLK_W-1:0] rk_q, rk_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [BLK_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [BLK_W-1:0] key_c, state_nxt_c, rk_nxt_c;
  logic             accept_c, last_c;

`ifdef AES_KEY_PORT_EN
  assign key_c = key_in;
`else
  assign key_c = FIXED_KEY;
`endif

  assign accept_c = in_valid & in_ready_q;
  assign last_c   = (rnd_q == RND_W'(NUM_ROUNDS));

  aes_enc_round u_round (
    .state_i     (data_q),
    .rk_i        (rk_q),
    .rcon_i      (rcon(rnd_q)),
    .last_i      (last_c),
    .state_nxt_c (state_nxt_c),
    .rk_nxt_c    (rk_nxt_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_c) state_d = ROUND;
      ROUND:   if (last_c) state_d = DONE;
      DONE:    if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs, all derived from the next state.
  always_comb begin
    data_d      = data_q;
    rk_d        = rk_q;
    rnd_d       = rnd_q;
    out_data_d  = out_data_q;
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == ROUND);
    out_valid_d = (state_d == DONE);
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          data_d = in_data ^ key_c;
          rk_d   = key_c;
          rnd_d  = RND_W'(1);
        end
      end
      ROUND: begin
        data_d = state_nxt_c;
        rk_d   = rk_nxt_c;
        rnd_d  = rnd_q + RND_W'(1);
        if (last_c) begin
          out_data_d = state_nxt_c;
          rnd_d      = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q      <= '0;
      rk_q        <= '0;
      rnd_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      data_q      <= data_d;
      rk_q        <= rk_d;
      rnd_q       <= rnd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule
